// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of {pc, pc+4, instr, adel}
// that absorbs icache-miss stalls on one side and decode stalls on the other.
module fetch_instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_pc_add_4,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_pc_add_4,
    output logic [WIDTH-1:0]         out_instr,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc_add_4;
        logic [WIDTH-1:0] instr;
        logic             adel;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_in_adel;
    entry_t          w_head;

    // Ready and valid depend on occupancy only: no pass-through when full, no bypass when empty.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_in_adel = |in_pc[1:0];

    assign w_head       = r_mem[r_rd_ptr];
    assign out_pc       = out_valid ? w_head.pc       : '0;
    assign out_pc_add_4 = out_valid ? w_head.pc_add_4 : '0;
    assign out_instr    = out_valid ? w_head.instr    : '0;
    assign out_adel     = out_valid ? w_head.adel     : 1'b0;

    // NOTE: the entry array has no reset; pointers and count alone define which entries are live,
    // so clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr].pc       <= in_pc;
            r_mem[r_wr_ptr].pc_add_4 <= in_pc_add_4;
            r_mem[r_wr_ptr].instr    <= w_in_adel ? '0 : in_instr;
            r_mem[r_wr_ptr].adel     <= w_in_adel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed self-checking bench for fetch_instr_queue: fill, full with simultaneous pop,
// flush, pointer wrap, misaligned PC and reset mid-operation.
module tb_fetch_instr_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_pc_add_4;
    logic [WIDTH-1:0] in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_pc_add_4;
    logic [WIDTH-1:0] out_instr;
    logic             out_adel;
    logic [2:0]       count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_pc_add_4  (in_pc_add_4),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_add_4 (out_pc_add_4),
        .out_instr    (out_instr),
        .out_adel     (out_adel),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_pc_add_4 = pc + 32'd4;
        in_instr    = instr;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_pc_add_4 = '0; in_instr = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_pc",    out_pc,         32'h0);
        check("rst_out_instr", out_instr,      32'h0);
        check("rst_out_adel",  32'(out_adel),  32'd0);

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive_push(32'hbfc00000 + 32'(4 * i), 32'h20000000 + 32'(i));
            tick();
            check("fill_count",  32'(count), 32'(i + 1));
            check("fill_out_pc", out_pc,     32'hbfc00000);
        end
        check("fill_in_ready",  32'(in_ready), 32'd0);
        drive_push(32'hbfc00010, 32'h20000004);
        tick();
        check("full_push_count",  32'(count), 32'd4);
        check("full_push_out_pc", out_pc,     32'hbfc00000);
        check("full_pc_add_4",    out_pc_add_4, 32'hbfc00004);
        check("full_instr",       out_instr,  32'h20000000);

        // Full: pop happens, push is rejected
        drive_push(32'hbfc00014, 32'h20000005);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("fullpop_count",    32'(count),    32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        check("fullpop_out_pc",   out_pc,        32'hbfc00004);
        check("fullpop_instr",    out_instr,     32'h20000001);

        // Flush with a same-cycle push
        flush = 1'b1;
        drive_push(32'h80000000, 32'h3c1d1234);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_instr", out_instr,      32'h0);
        check("flush_in_ready",  32'(in_ready),  32'd1);
        drive_push(32'h80000000, 32'h3c1d1234);
        tick();
        in_valid = 1'b0;
        check("postflush_valid", 32'(out_valid), 32'd1);
        check("postflush_pc",    out_pc,         32'h80000000);
        check("postflush_instr", out_instr,      32'h3c1d1234);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);

        // Wrap-around streaming (pointers start at 1, so they wrap twice)
        begin
            int exp_idx = 0;
            for (int k = 0; k <= 10; k++) begin
                if (k < 10) drive_push(32'(4 * k), 32'h10000000 + 32'(k));
                else        in_valid = 1'b0;
                out_ready = (k >= 1);
                if (out_ready && out_valid) begin
                    check("wrap_pop_pc",    out_pc,    32'(4 * exp_idx));
                    check("wrap_pop_instr", out_instr, 32'h10000000 + 32'(exp_idx));
                    exp_idx++;
                end
                tick();
                check("wrap_count_le1", 32'(count <= 3'd1), 32'd1);
            end
            check("wrap_pop_total", 32'(exp_idx), 32'd10);
            check("wrap_end_count", 32'(count),   32'd0);
        end
        out_ready = 1'b0;

        // Misaligned PC
        drive_push(32'hbfc00002, 32'h24020001);
        tick();
        in_valid = 1'b0;
        check("adel_flag",  32'(out_adel), 32'd1);
        check("adel_instr", out_instr,     32'h0);
        check("adel_pc",    out_pc,        32'hbfc00002);
        check("adel_pc4",   out_pc_add_4,  32'hbfc00006);

        // Reset mid-operation with a same-cycle push
        drive_push(32'hbfc00020, 32'h00000020);
        tick();
        check("premid_count", 32'(count), 32'd2);
        rst = 1'b1;
        drive_push(32'hbfc00024, 32'h00000024);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_count",     32'(count),     32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_pc",    out_pc,         32'h0);
        check("midrst_out_pc4",   out_pc_add_4,   32'h0);
        check("midrst_out_instr", out_instr,      32'h0);
        check("midrst_out_adel",  32'(out_adel),  32'd0);
        tick();
        check("midrst_idle_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
Instruction queue between the fetch stage and decode. It decouples icache-miss stalls in fetch from decode/hazard stalls. Fetch pushes {PC, PC+4, instruction} tuples. Decode pops them in order. A flush input empties the queue on branch redirect, jump, ERET or exception entry.

Parameters:
DEPTH, 4, number of entries; must be a power of 2, minimum 2.
WIDTH, 32, width of PC and instruction fields.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
flush  input  1  discard all entries; also blocks the push in the same cycle.
in_valid  input  1  fetch presents a valid instruction (PC stage not stalled, icache not missing).
in_ready  output  1  queue accepts a push this cycle.
in_pc  input  WIDTH  PC of the pushed instruction.
in_pc_add_4  input  WIDTH  PC+4 of the pushed instruction.
in_instr  input  WIDTH  instruction word from the icache.
out_valid  output  1  head entry is valid.
out_ready  input  1  decode consumes the head (low = decode stalled).
out_pc  output  WIDTH  head PC.
out_pc_add_4  output  WIDTH  head PC+4.
out_instr  output  WIDTH  head instruction.
out_adel  output  1  head PC was misaligned (instruction-fetch address error).
count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, pc_add_4, instr, adel}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits each and wrap naturally modulo DEPTH.
  - count is a separate register, range 0..DEPTH.
- Push condition: push = in_valid && in_ready && !flush.
  - Entry written at wr_ptr; wr_ptr increments.
  - adel = |in_pc[1:0].
  - If adel, the stored instr is forced to 32'h0 (NOP).
- Pop condition: pop = out_valid && out_ready && !flush. rd_ptr increments.
- in_ready = (count != DEPTH). It is combinational from count only and never depends on out_ready.
  - There is no pass-through when full: when full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). There is no bypass: minimum latency from push to out_valid is 1 cycle.
- Output data:
  - out_pc, out_pc_add_4, out_instr and out_adel come combinationally from the entry at rd_ptr when out_valid = 1.
  - When out_valid = 0, all four are driven to 0, so decode sees a NOP bubble.
- Count update:
  - push and not pop: +1.
  - pop and not push: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Priority:
  1. rst
  2. flush
  3. push/pop
- Reset (rst = 1 at posedge): rd_ptr = 0, wr_ptr = 0, count = 0.
  - Outputs after reset: out_valid = 0, in_ready = 1, out_* = 0, count = 0.
  - Entry contents need not be cleared.
  - Reset mid-operation discards all entries immediately.
- Flush (flush = 1 at posedge): rd_ptr = 0, wr_ptr = 0, count = 0.
  - Any same-cycle push and pop are ignored.
  - The next cycle shows out_valid = 0 and in_ready = 1.
  - A flush while empty is harmless.
- Boundary conditions:
  - Pop while empty: impossible, because out_valid = 0.
  - Push while full: ignored, because in_ready = 0. Fetch must hold its PC.
  - Simultaneous push and pop with 0 < count < DEPTH: both occur.
  - Pointer wrap: entry DEPTH-1 is followed by entry 0, with no bubble.
- Integration: fetch uses !in_ready as an additional PC-hold (StallF) term.

Test Plan:
- Fill: out_ready = 0; push PCs 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c -> count 1,2,3,4. in_ready = 0 after the 4th push. A 5th push of 0xbfc00010 is ignored. out_pc = 0xbfc00000 throughout.
- Full with simultaneous events: full queue, in_valid = 1, out_ready = 1 for one cycle -> head 0xbfc00000 popped, push rejected, count = 3, in_ready = 1 next cycle, out_pc = 0xbfc00004.
- Wrap-around: 10 pushes with PC 0x0,0x4,...,0x24 and out_ready = 1 continuously from the cycle after the first push -> 10 pops in PC order 0x0..0x24, count ≤ 1 throughout, no entry lost or duplicated.
- Flush: count = 3 and flush = 1 with in_valid = 1 (PC 0x80000000) in the same cycle -> next cycle count = 0, out_valid = 0, out_instr = 0. A push of 0x80000000 the following cycle appears at the head one cycle later.
- Misaligned PC: push in_pc = 0xbfc00002, in_instr = 0x24020001 -> head shows out_adel = 1, out_instr = 0, out_pc = 0xbfc00002.
- Reset mid-operation: count = 2, rst = 1 for one cycle with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1, out_* = 0. The push in the reset cycle is discarded.
